// File: rtl/pll_seq_pkg.sv
// PLL reset sequencer shared types.
// State encoding and small decode helpers.
package pll_seq_pkg;

    localparam logic [2:0] ENC_RST_PLL   = 3'd0;
    localparam logic [2:0] ENC_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ENC_STABLE    = 3'd2;
    localparam logic [2:0] ENC_RUN       = 3'd3;
    localparam logic [2:0] ENC_FAULT     = 3'd4;

    typedef enum logic [2:0] {
        RST_PLL   = ENC_RST_PLL,
        WAIT_LOCK = ENC_WAIT_LOCK,
        STABLE    = ENC_STABLE,
        RUN       = ENC_RUN,
        FAULT     = ENC_FAULT
    } state_t;

    // PLL RESETB is held low while (re)starting and while parked in FAULT.
    function automatic logic holds_pll_reset(state_t s);
        return (s == RST_PLL) || (s == FAULT);
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// PLL reset sequencer status/control bundle.
// master = sequencer side, slave = board/PLL side.
interface pll_reset_sequencer_if;

    logic       pll_locked;
    logic       restart;
    logic       pll_resetb;
    logic       sys_reset;
    logic       ready;
    logic       fault;
    logic [1:0] retry_count;
    logic [7:0] loss_count;

    modport master (
        input  pll_locked,
        input  restart,
        output pll_resetb,
        output sys_reset,
        output ready,
        output fault,
        output retry_count,
        output loss_count
    );

    modport slave (
        output pll_locked,
        output restart,
        input  pll_resetb,
        input  sys_reset,
        input  ready,
        input  fault,
        input  retry_count,
        input  loss_count
    );

endinterface

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser.
// Used for asynchronous status inputs such as PLL LOCK.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give metastability a full cycle to settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// SB_PLL40 bring-up sequencer on the 12 MHz reference clock.
// Pulses RESETB, waits/qualifies LOCK, then releases sys_reset.
module pll_reset_sequencer #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 12000,
    parameter int unsigned STABLE_CYCLES = 1200,
    parameter int unsigned MAX_RETRIES   = 3,
    parameter int unsigned CNT_W         = 16
) (
    input logic clock_in,
    input logic reset,
    pll_reset_sequencer_if.master bus
);

    import pll_seq_pkg::*;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRIES);

    logic             lk;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       retry_q, retry_d, retry_inc;
    logic [7:0]       loss_q, loss_d;
    logic             resetb_q, sys_reset_q, ready_q, fault_q;

    sync_2ff u_lock_sync (
        .clk (clock_in),
        .rst (reset),
        .d   (bus.pll_locked),
        .q   (lk)
    );

    assign retry_inc = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;

    // Next state, shared counter and event counters; restart beats any state event.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        if (bus.restart) begin
            state_d = RST_PLL;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            unique case (state_q)
                RST_PLL: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (lk) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        retry_d = retry_inc;
                        cnt_d   = '0;
                        state_d = (retry_inc == RETRY_LIMIT) ? FAULT : RST_PLL;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STABLE: begin
                    if (!lk) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (!lk) begin
                        state_d = RST_PLL;
                        cnt_d   = '0;
                        retry_d = '0;
                        loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = RST_PLL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counter and event-count registers.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q <= RST_PLL;
            cnt_q   <= '0;
            retry_q <= '0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            loss_q  <= loss_d;
        end
    end

    // Outputs decoded from the next state so they line up with the state itself.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            resetb_q    <= 1'b0;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            resetb_q    <= !holds_pll_reset(state_d);
            sys_reset_q <= (state_d != RUN);
            ready_q     <= (state_d == RUN);
            fault_q     <= (state_d == FAULT);
        end
    end

    assign bus.pll_resetb  = resetb_q;
    assign bus.sys_reset   = sys_reset_q;
    assign bus.ready       = ready_q;
    assign bus.fault       = fault_q;
    assign bus.retry_count = retry_q;
    assign bus.loss_count  = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed scoreboard bench for pll_reset_sequencer.
// Small timing parameters keep every scenario short.
module tb_pll_reset_sequencer;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic clk;
    logic reset;
    exp_t sb[$];
    int   checks;
    int   errors;

    pll_reset_sequencer_if bus();

    pll_reset_sequencer #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (3),
        .CNT_W         (16)
    ) dut (
        .clock_in (clk),
        .reset    (reset),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL sb_empty observed %0d expected <entry>", obs);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed %0d expected %0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic push_outs(input string tag, input logic rb, input logic sr,
                             input logic rd, input logic ft,
                             input logic [1:0] rc, input logic [7:0] lc);
        push({tag, "_resetb"}, 32'(rb));
        push({tag, "_sysrst"}, 32'(sr));
        push({tag, "_ready"}, 32'(rd));
        push({tag, "_fault"}, 32'(ft));
        push({tag, "_retry"}, 32'(rc));
        push({tag, "_loss"}, 32'(lc));
    endtask

    task automatic cmp_outs();
        pop_cmp(32'(bus.pll_resetb));
        pop_cmp(32'(bus.sys_reset));
        pop_cmp(32'(bus.ready));
        pop_cmp(32'(bus.fault));
        pop_cmp(32'(bus.retry_count));
        pop_cmp(32'(bus.loss_count));
    endtask

    // Number of consecutive samples (starting now) with pll_resetb at lvl.
    task automatic count_resetb(input logic lvl, output int n);
        n = 0;
        while (bus.pll_resetb === lvl && n < 100) begin
            n++;
            step();
        end
    endtask

    // Cycles until ready rises; 100 means it never did.
    task automatic wait_ready(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (bus.ready !== 1'b1 && n < 100);
    endtask

    task automatic drop_relock();
        int n;
        bus.pll_locked = 1'b0;
        n = 0;
        while (bus.ready !== 1'b0 && n < 20) begin
            step();
            n++;
        end
        bus.pll_locked = 1'b1;
        wait_ready(n);
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.pll_locked = 1'b0;
        bus.restart = 1'b0;
        repeat (3) step();
        push_outs("reset", 0, 1, 0, 0, 0, 0);
        cmp_outs();

        reset = 1'b0;
        count_resetb(1'b0, n);
        push("clean_rstb_low", 4);
        pop_cmp(n);
        repeat (5) step();
        bus.pll_locked = 1'b1;
        wait_ready(n);
        push("clean_ready_lat", 11);
        pop_cmp(n);
        push_outs("clean_run", 1, 0, 1, 0, 0, 0);
        cmp_outs();

        bus.pll_locked = 1'b0;
        repeat (2) step();
        push("loss_ready_hold", 1);
        pop_cmp(32'(bus.ready));
        step();
        push_outs("loss", 0, 1, 0, 0, 0, 1);
        cmp_outs();
        count_resetb(1'b0, n);
        push("loss_rstb_low", 4);
        pop_cmp(n);

        bus.pll_locked = 1'b1;
        repeat (5) step();
        bus.pll_locked = 1'b0;
        step();
        bus.pll_locked = 1'b1;
        wait_ready(n);
        push("glitch_ready_lat", 17);
        pop_cmp(n + 6);
        push_outs("relock", 1, 0, 1, 0, 0, 1);
        cmp_outs();

        bus.pll_locked = 1'b0;
        repeat (2) step();
        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        push_outs("restart_drop", 0, 1, 0, 0, 0, 1);
        cmp_outs();

        for (int k = 1; k <= 3; k++) begin
            count_resetb(1'b0, n);
            push("to_rstb_low", 4);
            pop_cmp(n);
            count_resetb(1'b1, n);
            push("to_wait_len", 20);
            pop_cmp(n);
            push("to_retry", 32'(k));
            pop_cmp(32'(bus.retry_count));
            push("to_fault", 32'(k == 3));
            pop_cmp(32'(bus.fault));
        end
        repeat (20) step();
        push_outs("fault_hold", 0, 1, 0, 1, 3, 1);
        cmp_outs();

        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        push_outs("restart_fault", 0, 1, 0, 0, 0, 1);
        cmp_outs();
        count_resetb(1'b0, n);
        push("restart_rstb_low", 4);
        pop_cmp(n);
        repeat (5) step();
        bus.pll_locked = 1'b1;
        wait_ready(n);
        push("restart_ready_lat", 11);
        pop_cmp(n);
        push_outs("restart_run", 1, 0, 1, 0, 0, 1);
        cmp_outs();

        repeat (253) drop_relock();
        push("loss_254", 254);
        pop_cmp(32'(bus.loss_count));
        drop_relock();
        push("loss_255", 255);
        pop_cmp(32'(bus.loss_count));
        repeat (4) drop_relock();
        push("loss_sat", 255);
        pop_cmp(32'(bus.loss_count));
        push("loss_sat_ready", 1);
        pop_cmp(32'(bus.ready));

        reset = 1'b1;
        step();
        push_outs("reset_run", 0, 1, 0, 0, 0, 0);
        cmp_outs();
        reset = 1'b0;
        repeat (7) step();
        push("stable_resetb", 1);
        pop_cmp(32'(bus.pll_resetb));
        push("stable_ready", 0);
        pop_cmp(32'(bus.ready));
        reset = 1'b1;
        step();
        push_outs("reset_stable", 0, 1, 0, 0, 0, 0);
        cmp_outs();
        reset = 1'b0;
        count_resetb(1'b0, n);
        push("post_reset_rstb_low", 4);
        pop_cmp(n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
